// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/time-set controller for the MM:SS seven-segment clock.
// Owns the 1 Hz divider, the BCD minute/second counters and the run/set
// mode sequencing driven by the MODE/INC/CLR push inputs.
// Optional build macro: CLOCK_SET_BLINK_EN enables the set-mode digit blink
// (BLANK output); without it BLANK is tied low and no blink logic exists.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_RUN  | time advances on TICK, INC ignored
// ST_SMIN | divider held, INC bumps minutes mod 60
// ST_SSEC | divider held, INC bumps seconds mod 60
// ST_BAD  | unreachable encoding, recovers to ST_RUN
module clock_set_ctrl #(
    parameter int DIV       = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] SW,
    output logic [3:0] SEC_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] MIN_TENS,
    output logic [1:0] MODE,
    output logic       TICK,
    output logic [3:0] BLANK
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_SMIN = 2'b01,
        ST_SSEC = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    localparam int             DW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);

    state_t        state_q, state_d;
    logic [2:0]    sw_s1, sw_s2, sw_s3;
    logic [2:0]    sw_pulse;
    logic          mode_p, inc_p, clr_p, mode_adv;
    logic [DW-1:0] div_cnt;
    logic [7:0]    sec_q, min_q;
    logic          unused_sw3;

    // SW[3] is reserved and deliberately left unconnected
    assign unused_sw3 = SW[3];

    // BCD increment of a two-digit value, wrapping 59 -> 00
    function automatic logic [7:0] inc60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // two-flop synchronizer plus a delay stage for rising-edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_s1 <= 3'b000;
            sw_s2 <= 3'b000;
            sw_s3 <= 3'b000;
        end else begin
            sw_s1 <= SW[2:0];
            sw_s2 <= sw_s1;
            sw_s3 <= sw_s2;
        end
    end

    assign sw_pulse = sw_s2 & ~sw_s3;
    assign mode_p   = sw_pulse[0];
    assign inc_p    = sw_pulse[1];
    assign clr_p    = sw_pulse[2];
    // CLR outranks MODE and leaves the mode untouched
    assign mode_adv = mode_p & ~clr_p;

    // mode state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // next-mode decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (mode_adv) state_d = ST_SMIN;
            ST_SMIN: if (mode_adv) state_d = ST_SSEC;
            ST_SSEC: if (mode_adv) state_d = ST_RUN;
            ST_BAD:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign TICK = (state_q == ST_RUN) && (div_cnt == DIV_LAST);

    // 1 Hz divider: free-running in RUN, parked at 0 otherwise or on CLR/mode change
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
        end else if (clr_p || mode_adv || (state_q != ST_RUN)) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // time registers: CLR > MODE > INC > TICK, all digits move on one edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sec_q <= 8'h00;
            min_q <= 8'h00;
        end else if (clr_p) begin
            sec_q <= 8'h00;
            min_q <= 8'h00;
        end else if (mode_adv) begin
            sec_q <= sec_q;
            min_q <= min_q;
        end else if (inc_p) begin
            if (state_q == ST_SMIN) min_q <= inc60(min_q);
            if (state_q == ST_SSEC) sec_q <= inc60(sec_q);
        end else if (TICK) begin
            sec_q <= inc60(sec_q);
            if (sec_q == 8'h59) min_q <= inc60(min_q);
        end
    end

    assign SEC_ONES = sec_q[3:0];
    assign SEC_TENS = sec_q[7:4];
    assign MIN_ONES = min_q[3:0];
    assign MIN_TENS = min_q[7:4];
    assign MODE     = state_q;

`ifdef CLOCK_SET_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic [3:0]    blank_q;
    logic          mode_chg;

    assign mode_chg = (state_d != state_q);

    // blink phase generator, restarted whenever the mode moves
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if ((state_q == ST_RUN) || mode_chg) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // registered blank request for the digit pair being edited
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                  blank_q <= 4'b0000;
        else if (blink_ph && state_q == ST_SMIN)  blank_q <= 4'b1100;
        else if (blink_ph && state_q == ST_SSEC)  blank_q <= 4'b0011;
        else                                      blank_q <= 4'b0000;
    end

    assign BLANK = blank_q;
`else
    localparam int unused_blink_div = BLINK_DIV;

    assign BLANK = 4'b0000;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with DIV=10, BLINK_DIV=4.
module tb_clock_set_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] SW  = 4'b0000;
    logic [3:0] SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS;
    logic [1:0] MODE;
    logic       TICK;
    logic [3:0] BLANK;

`ifdef CLOCK_SET_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    int vectors = 0;
    int errors  = 0;
    int tick_total = 0;

    clock_set_ctrl #(.DIV(10), .BLINK_DIV(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SW       (SW),
        .SEC_ONES (SEC_ONES),
        .SEC_TENS (SEC_TENS),
        .MIN_ONES (MIN_ONES),
        .MIN_TENS (MIN_TENS),
        .MODE     (MODE),
        .TICK     (TICK),
        .BLANK    (BLANK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] digits();
        return {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (TICK === 1'b1) tick_total++;
        end
    endtask

    task automatic press(input logic [3:0] m);
        SW = m;
        step(3);
        SW = 4'b0000;
        step(3);
    endtask

    initial begin
        int last, first, ticks, bad_gap, t0;
        logic [3:0] exp_blank;

        // reset state
        #1 RST = 1'b1;
        step(2);
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_mode",   {14'd0, MODE}, 16'd0);
        chk("rst_tick",   {15'd0, TICK}, 16'd0);
        chk("rst_blank",  {12'd0, BLANK}, 16'd0);
        RST = 1'b0;

        // 1: 600 cycles of RUN
        last = -1; first = -1; ticks = 0; bad_gap = 0;
        for (int k = 1; k <= 600; k++) begin
            step(1);
            if (TICK === 1'b1) begin
                ticks++;
                if (last >= 0 && (k - last) != 10) bad_gap++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("t1_ticks",   16'(ticks), 16'd60);
        chk("t1_first",   16'(first), 16'd9);
        chk("t1_gap",     16'(bad_gap), 16'd0);
        chk("t1_digits",  digits(), 16'h0100);
        chk("t1_mode",    {14'd0, MODE}, 16'd0);

        // 2: preload 59:58 and roll over
        press(4'b0001);
        chk("t2_setmin",  {14'd0, MODE}, 16'd1);
        chk("t2_hold",    digits(), 16'h0100);
        for (int i = 0; i < 58; i++) press(4'b0010);
        chk("t2_min59",   digits(), 16'h5900);
        press(4'b0001);
        chk("t2_setsec",  {14'd0, MODE}, 16'd2);
        for (int i = 0; i < 58; i++) press(4'b0010);
        chk("t2_5958",    digits(), 16'h5958);
        press(4'b0001);
        chk("t2_run",     {14'd0, MODE}, 16'd0);
        chk("t2_norun",   digits(), 16'h5958);
        step(7);
        chk("t2_5959",    digits(), 16'h5959);
        step(10);
        chk("t2_wrap",    digits(), 16'h0000);
        chk("t2_mode",    {14'd0, MODE}, 16'd0);

        // 3: set-minutes with three INC, no TICK while setting
        press(4'b0001);
        t0 = tick_total;
        for (int i = 0; i < 3; i++) press(4'b0010);
        chk("t3_mode",    {14'd0, MODE}, 16'd1);
        chk("t3_digits",  digits(), 16'h0300);
        chk("t3_noticks", 16'(tick_total - t0), 16'd0);

        // 4: CLR in SET_MIN, seconds wrap without carry
        press(4'b0100);
        chk("t4_clr",     digits(), 16'h0000);
        chk("t4_clrmode", {14'd0, MODE}, 16'd1);
        press(4'b0001);
        for (int i = 0; i < 59; i++) press(4'b0010);
        chk("t4_0059",    digits(), 16'h0059);
        press(4'b0010);
        chk("t4_nocarry", digits(), 16'h0000);
        press(4'b0001);
        chk("t4_run",     {14'd0, MODE}, 16'd0);

        // 5: CLR colliding with TICK at 12:34
        press(4'b0001);
        for (int i = 0; i < 12; i++) press(4'b0010);
        press(4'b0001);
        for (int i = 0; i < 34; i++) press(4'b0010);
        chk("t5_1234",    digits(), 16'h1234);
        press(4'b0001);
        chk("t5_run",     {14'd0, MODE}, 16'd0);
        step(4);
        SW = 4'b0100;
        step(2);
        chk("t5_tickdue", {15'd0, TICK}, 16'd1);
        step(1);
        chk("t5_clrtick", digits(), 16'h0000);
        SW = 4'b0000;
        step(3);
        press(4'b0011);
        chk("t5_modeinc", {14'd0, MODE}, 16'd1);
        chk("t5_incdrop", digits(), 16'h0000);

        // 6: blink in SET_MIN, then reset mid-set
        press(4'b0001);
        press(4'b0001);
        chk("t6_run",     {14'd0, MODE}, 16'd0);
        SW = 4'b0001;
        step(3);
        chk("t6_setmin",  {14'd0, MODE}, 16'd1);
        SW = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            exp_blank = (BLINK_ON && (((k - 1) / 4) % 2 == 1)) ? 4'b1100 : 4'b0000;
            chk($sformatf("t6_blank_%0d", k), {12'd0, BLANK}, {12'd0, exp_blank});
        end
        press(4'b0010);
        chk("t6_pre_rst", digits(), 16'h0100);
        SW = 4'b0001;
        step(1);
        #2 RST = 1'b1;
        #1;
        chk("t6_rst_dig", digits(), 16'h0000);
        chk("t6_rst_mode", {14'd0, MODE}, 16'd0);
        chk("t6_rst_tick", {15'd0, TICK}, 16'd0);
        chk("t6_rst_blk", {12'd0, BLANK}, 16'd0);
        SW = 4'b0000;
        step(1);
        RST = 1'b0;
        step(5);
        chk("t6_post_mode", {14'd0, MODE}, 16'd0);
        chk("t6_post_dig", digits(), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
